// File: rtl/sccb_pkg.sv
// Shared types and constants for the SCCB/I2C responder model.
package sccb_pkg;

    localparam int unsigned SHCNT_W  = 4;
    localparam logic        RW_WRITE = 1'b0;
    localparam logic        RW_READ  = 1'b1;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_DEV,
        ST_DACK,
        ST_RA_H,
        ST_RA_L,
        ST_RACK,
        ST_WR,
        ST_WACK,
        ST_RD,
        ST_MACK,
        ST_IGNORE
    } sccb_state_e;

endpackage

// File: rtl/sccb_line_sync.sv
// Synchronises scl/sda to clk and produces registered edge, START and STOP strobes.
module sccb_line_sync (
    input  logic clk,
    input  logic rst,
    input  logic scl_i,
    input  logic sda_i,
    output logic scl_rise,
    output logic scl_fall,
    output logic start,
    output logic stop,
    output logic sda_s
);

    logic scl_meta_q, scl_sync_q, scl_prev_q;
    logic sda_meta_q, sda_sync_q, sda_prev_q;
    logic rise_d, fall_d, start_d, stop_d;
    logic rise_q, fall_q, start_q, stop_q;

    always_comb begin
        rise_d  = scl_sync_q & ~scl_prev_q;
        fall_d  = ~scl_sync_q & scl_prev_q;
        start_d = scl_sync_q & scl_prev_q & sda_prev_q & ~sda_sync_q;
        stop_d  = scl_sync_q & scl_prev_q & ~sda_prev_q & sda_sync_q;
    end

    // Lines idle high, so the pipeline resets to 1 to avoid spurious events.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_meta_q <= 1'b1;
            scl_sync_q <= 1'b1;
            scl_prev_q <= 1'b1;
            sda_meta_q <= 1'b1;
            sda_sync_q <= 1'b1;
            sda_prev_q <= 1'b1;
            rise_q     <= 1'b0;
            fall_q     <= 1'b0;
            start_q    <= 1'b0;
            stop_q     <= 1'b0;
        end else begin
            scl_meta_q <= scl_i;
            scl_sync_q <= scl_meta_q;
            scl_prev_q <= scl_sync_q;
            sda_meta_q <= sda_i;
            sda_sync_q <= sda_meta_q;
            sda_prev_q <= sda_sync_q;
            rise_q     <= rise_d;
            fall_q     <= fall_d;
            start_q    <= start_d;
            stop_q     <= stop_d;
        end
    end

    assign scl_rise = rise_q;
    assign scl_fall = fall_q;
    assign start    = start_q;
    assign stop     = stop_q;
    assign sda_s    = sda_prev_q;

endmodule

// File: rtl/sccb_slave_model.sv
// SCCB/I2C register-file responder: decodes device/address/data bytes, ACKs and serves reads open-drain.
module sccb_slave_model
    import sccb_pkg::*;
#(
    parameter logic [6:0]  DEV_ADDR = 7'h21,
    parameter bit          ADDR16   = 1'b0,
    parameter int unsigned AW       = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          scl_i,
    input  logic          sda_i,
    output logic          sda_oe,
    output logic          reg_wr_en,
    output logic [15:0]   reg_wr_addr,
    output logic [7:0]    reg_wr_data,
    output logic          busy,
    input  logic [AW-1:0] dbg_addr,
    output logic [7:0]    dbg_data
);

    localparam int unsigned DEPTH = 2 ** AW;

    logic scl_rise, scl_fall, ev_start, ev_stop, sda_s;

    sccb_line_sync u_sync (
        .clk      (clk),
        .rst      (rst),
        .scl_i    (scl_i),
        .sda_i    (sda_i),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .start    (ev_start),
        .stop     (ev_stop),
        .sda_s    (sda_s)
    );

    sccb_state_e          state_q, state_d, ret_q, ret_d;
    logic [SHCNT_W-1:0]   cnt_q, cnt_d;
    logic [7:0]           shreg_q, shreg_d, tx_q, tx_d, hi_q, hi_d;
    logic [AW-1:0]        ptr_q, ptr_d, ptr_inc;
    logic                 sda_oe_q, sda_oe_d, busy_q, busy_d, wr_en_q, wr_en_d;
    logic [15:0]          wr_addr_q, wr_addr_d;
    logic [7:0]           wr_data_q, wr_data_d, dbg_data_q, dbg_data_d;
    logic                 mem_we;
    logic [7:0]           mem_q [DEPTH];
    logic [7:0]           rd_cur, rd_nxt;
    logic                 byte_done, glitch;

    assign ptr_inc   = ptr_q + AW'(1);
    assign rd_cur    = mem_q[ptr_q];
    assign rd_nxt    = mem_q[ptr_inc];
    assign byte_done = scl_fall && (cnt_q == SHCNT_W'(8));
    assign glitch    = (scl_rise || scl_fall) && (cnt_q > SHCNT_W'(9));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            ret_q      <= ST_IDLE;
            cnt_q      <= '0;
            shreg_q    <= '0;
            tx_q       <= '0;
            hi_q       <= '0;
            ptr_q      <= '0;
            sda_oe_q   <= 1'b0;
            busy_q     <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            dbg_data_q <= '0;
        end else begin
            state_q    <= state_d;
            ret_q      <= ret_d;
            cnt_q      <= cnt_d;
            shreg_q    <= shreg_d;
            tx_q       <= tx_d;
            hi_q       <= hi_d;
            ptr_q      <= ptr_d;
            sda_oe_q   <= sda_oe_d;
            busy_q     <= busy_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            dbg_data_q <= dbg_data_d;
        end
    end

    // Register file contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[ptr_q] <= shreg_q;
        end
    end

    // Next state; ret_q holds where an ACK slot leads once it ends.
    always_comb begin
        state_d = state_q;
        ret_d   = ret_q;
        if (ev_start) begin
            state_d = ST_DEV;
        end else if (ev_stop) begin
            state_d = ST_IDLE;
        end else if (glitch) begin
            state_d = ST_IGNORE;
        end else begin
            case (state_q)
                ST_DEV: if (byte_done) begin
                    if (shreg_q[7:1] == DEV_ADDR) begin
                        state_d = ST_DACK;
                        ret_d   = (shreg_q[0] == RW_READ) ? ST_RD : (ADDR16 ? ST_RA_H : ST_RA_L);
                    end else begin
                        state_d = ST_IGNORE;
                    end
                end
                ST_RA_H: if (byte_done) begin
                    state_d = ST_RACK;
                    ret_d   = ST_RA_L;
                end
                ST_RA_L: if (byte_done) begin
                    state_d = ST_RACK;
                    ret_d   = ST_WR;
                end
                ST_WR: if (byte_done) begin
                    state_d = ST_WACK;
                    ret_d   = ST_WR;
                end
                ST_DACK, ST_RACK, ST_WACK: if (scl_fall) state_d = ret_q;
                ST_RD: if (byte_done) state_d = ST_MACK;
                ST_MACK: if (scl_fall && cnt_q != '0) begin
                    state_d = (shreg_q[0] == 1'b0) ? ST_RD : ST_IGNORE;
                end
                default: ;
            endcase
        end
    end

    // Datapath and outputs; sda_oe only ever changes on an scl fall or a bus condition.
    always_comb begin
        cnt_d      = cnt_q;
        shreg_d    = shreg_q;
        tx_d       = tx_q;
        hi_d       = hi_q;
        ptr_d      = ptr_q;
        sda_oe_d   = sda_oe_q;
        busy_d     = busy_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        mem_we     = 1'b0;
        dbg_data_d = mem_q[dbg_addr];
        if (ev_start) begin
            cnt_d    = '0;
            sda_oe_d = 1'b0;
            busy_d   = 1'b1;
        end else if (ev_stop) begin
            cnt_d    = '0;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else if (glitch) begin
            cnt_d    = '0;
            sda_oe_d = 1'b0;
        end else begin
            case (state_q)
                ST_DEV, ST_RA_H, ST_RA_L, ST_WR, ST_MACK: begin
                    if (scl_rise) begin
                        shreg_d = {shreg_q[6:0], sda_s};
                        cnt_d   = cnt_q + SHCNT_W'(1);
                    end
                    if (byte_done && state_q != ST_MACK) begin
                        cnt_d    = '0;
                        sda_oe_d = 1'b1;
                        case (state_q)
                            ST_DEV:  sda_oe_d = (shreg_q[7:1] == DEV_ADDR);
                            ST_RA_H: hi_d = shreg_q;
                            ST_RA_L: ptr_d = AW'({hi_q, shreg_q});
                            default: begin
                                mem_we    = 1'b1;
                                wr_en_d   = 1'b1;
                                wr_addr_d = 16'(ptr_q);
                                wr_data_d = shreg_q;
                                ptr_d     = ptr_inc;
                            end
                        endcase
                    end
                    if (state_q == ST_MACK && scl_fall && cnt_q != '0) begin
                        cnt_d = '0;
                        if (shreg_q[0] == 1'b0) begin
                            ptr_d    = ptr_inc;
                            tx_d     = rd_nxt;
                            sda_oe_d = ~rd_nxt[7];
                        end else begin
                            busy_d = 1'b0;
                        end
                    end
                end
                ST_DACK, ST_RACK, ST_WACK: if (scl_fall) begin
                    cnt_d    = '0;
                    sda_oe_d = 1'b0;
                    if (ret_q == ST_RD) begin
                        tx_d     = rd_cur;
                        sda_oe_d = ~rd_cur[7];
                    end
                end
                ST_RD: begin
                    if (scl_rise) cnt_d = cnt_q + SHCNT_W'(1);
                    if (byte_done) begin
                        cnt_d    = '0;
                        sda_oe_d = 1'b0;
                    end else if (scl_fall && cnt_q != '0) begin
                        sda_oe_d = ~tx_q[6];
                        tx_d     = {tx_q[6:0], 1'b0};
                    end
                end
                default: ;
            endcase
        end
    end

    assign sda_oe      = sda_oe_q;
    assign busy        = busy_q;
    assign reg_wr_en   = wr_en_q;
    assign reg_wr_addr = wr_addr_q;
    assign reg_wr_data = wr_data_q;
    assign dbg_data    = dbg_data_q;

endmodule

// File: tb/tb_sccb_slave_model.sv
// Directed bench for sccb_slave_model: a bit-banged SCCB master at clk/16 on an open-drain sda.
module tb_sccb_slave_model;

    logic        clk, rst, scl_m, sda_m, sda_line;
    logic        sda_oe, reg_wr_en, busy;
    logic [15:0] reg_wr_addr;
    logic [7:0]  reg_wr_data, dbg_data, dbg_addr;
    int          n_checks = 0;
    int          n_errors = 0;
    int          oe_cycles = 0;
    logic [15:0] wa_log[$];
    logic [7:0]  wd_log[$];

    assign sda_line = sda_m & ~sda_oe;

    sccb_slave_model dut (
        .clk         (clk),
        .rst         (rst),
        .scl_i       (scl_m),
        .sda_i       (sda_line),
        .sda_oe      (sda_oe),
        .reg_wr_en   (reg_wr_en),
        .reg_wr_addr (reg_wr_addr),
        .reg_wr_data (reg_wr_data),
        .busy        (busy),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (reg_wr_en === 1'b1) begin
            wa_log.push_back(reg_wr_addr);
            wd_log.push_back(reg_wr_data);
        end
        if (sda_oe === 1'b1) oe_cycles++;
    end

    task automatic bus_start();
        #20 sda_m = 1'b1;
        #20 scl_m = 1'b1;
        #40 sda_m = 1'b0;
        #40 scl_m = 1'b0;
    endtask

    task automatic bus_stop();
        #20 sda_m = 1'b0;
        #60 scl_m = 1'b1;
        #40 sda_m = 1'b1;
        #80;
    endtask

    task automatic bit_out(input logic b);
        #20 sda_m = b;
        #60 scl_m = 1'b1;
        #80 scl_m = 1'b0;
    endtask

    task automatic bit_in(output logic b);
        #20 sda_m = 1'b1;
        #60 scl_m = 1'b1;
        #40 b = sda_line;
        #40 scl_m = 1'b0;
    endtask

    task automatic byte_out(input logic [7:0] v, output logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) bit_out(v[i]);
        bit_in(b);
        ack = ~b;
    endtask

    task automatic byte_in(output logic [7:0] v);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            bit_in(b);
            v[i] = b;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; scl_m = 1'b1; sda_m = 1'b1; dbg_addr = 8'h00;
        #40;
        n_checks++; if (sda_oe !== 1'b0) begin n_errors++; $display("FAIL reset_sda_oe got %b want 0", sda_oe); end
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy got %b want 0", busy); end
        n_checks++; if ({reg_wr_en, reg_wr_addr, reg_wr_data} !== 25'h0) begin
            n_errors++; $display("FAIL reset_wr_port got %b/%h/%h want 0/0000/00", reg_wr_en, reg_wr_addr, reg_wr_data); end
        n_checks++; if (dbg_data !== 8'h00) begin n_errors++; $display("FAIL reset_dbg_data got %h want 00", dbg_data); end
        rst = 1'b0;
        #40;
    endtask

    task automatic test_single_write();
        logic a0, a1, a2;
        int base = wa_log.size();
        bus_start();
        byte_out(8'h42, a0); byte_out(8'h12, a1); byte_out(8'h80, a2);
        bus_stop();
        n_checks++; if ({a0, a1, a2} !== 3'b111) begin n_errors++; $display("FAIL single_acks got %b want 111", {a0, a1, a2}); end
        n_checks++; if (wa_log.size() - base !== 1) begin n_errors++; $display("FAIL single_count got %0d want 1", wa_log.size() - base); end
        else begin
            n_checks++; if (wa_log[base] !== 16'h0012) begin n_errors++; $display("FAIL single_addr got %h want 0012", wa_log[base]); end
            n_checks++; if (wd_log[base] !== 8'h80) begin n_errors++; $display("FAIL single_data got %h want 80", wd_log[base]); end
        end
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL single_busy_after_stop got %b want 0", busy); end
        dbg_addr = 8'h12;
        #30;
        n_checks++; if (dbg_data !== 8'h80) begin n_errors++; $display("FAIL single_dbg got %h want 80", dbg_data); end
    endtask

    task automatic test_wrong_dev();
        logic a0, a1, a2;
        int base = wa_log.size();
        int oe0 = oe_cycles;
        bus_start();
        byte_out(8'h44, a0);
        n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL wrongdev_busy_mid got %b want 1", busy); end
        byte_out(8'h12, a1); byte_out(8'h55, a2);
        bus_stop();
        n_checks++; if ({a0, a1, a2} !== 3'b000) begin n_errors++; $display("FAIL wrongdev_acks got %b want 000", {a0, a1, a2}); end
        n_checks++; if (oe_cycles - oe0 !== 0) begin n_errors++; $display("FAIL wrongdev_oe_cycles got %0d want 0", oe_cycles - oe0); end
        n_checks++; if (wa_log.size() - base !== 0) begin n_errors++; $display("FAIL wrongdev_writes got %0d want 0", wa_log.size() - base); end
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL wrongdev_busy_after_stop got %b want 0", busy); end
    endtask

    task automatic test_burst_wrap();
        logic [15:0] exp_a [3] = '{16'h00FF, 16'h0000, 16'h0001};
        logic [7:0]  exp_d [3] = '{8'hA1, 8'hA2, 8'hA3};
        logic [4:0]  acks;
        logic        a;
        int base = wa_log.size();
        bus_start();
        byte_out(8'h42, a); acks[4] = a;
        byte_out(8'hFF, a); acks[3] = a;
        for (int i = 0; i < 3; i++) begin
            byte_out(exp_d[i], a); acks[2-i] = a;
        end
        bus_stop();
        n_checks++; if (acks !== 5'b11111) begin n_errors++; $display("FAIL burst_acks got %b want 11111", acks); end
        n_checks++; if (wa_log.size() - base !== 3) begin n_errors++; $display("FAIL burst_count got %0d want 3", wa_log.size() - base); end
        else begin
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (wa_log[base+i] !== exp_a[i] || wd_log[base+i] !== exp_d[i]) begin
                    n_errors++;
                    $display("FAIL burst_write%0d got %h=%h want %h=%h", i, wa_log[base+i], wd_log[base+i], exp_a[i], exp_d[i]);
                end
            end
        end
    endtask

    task automatic test_two_phase_read();
        logic       a0, a1, a2, a3;
        logic [7:0] r0, r1;
        int base;
        bus_start();
        byte_out(8'h42, a0); byte_out(8'h1C, a0); byte_out(8'h7F, a0); byte_out(8'hA2, a0);
        bus_stop();
        base = wa_log.size();
        bus_start();
        byte_out(8'h42, a0); byte_out(8'h1C, a1);
        bus_stop();
        bus_start();
        byte_out(8'h43, a2);
        byte_in(r0);
        bit_out(1'b0);
        byte_in(r1);
        bit_out(1'b1);
        #100;
        n_checks++; if ({a0, a1, a2} !== 3'b111) begin n_errors++; $display("FAIL rd_acks got %b want 111", {a0, a1, a2}); end
        n_checks++; if (r0 !== 8'h7F) begin n_errors++; $display("FAIL rd_byte0 got %h want 7f", r0); end
        n_checks++; if (r1 !== 8'hA2) begin n_errors++; $display("FAIL rd_byte1 got %h want a2", r1); end
        n_checks++; if (sda_oe !== 1'b0) begin n_errors++; $display("FAIL rd_release_after_nack got %b want 0", sda_oe); end
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL rd_busy_after_nack got %b want 0", busy); end
        bus_stop();
        a3 = (wa_log.size() != base);
        n_checks++; if (a3 !== 1'b0) begin n_errors++; $display("FAIL rd_no_writes got %0d want 0", wa_log.size() - base); end
    endtask

    task automatic test_partial_stop();
        logic       a;
        logic [4:0] part = 5'b10110;
        int base = wa_log.size();
        bus_start();
        byte_out(8'h42, a); byte_out(8'h20, a);
        for (int i = 4; i >= 0; i--) bit_out(part[i]);
        bus_stop();
        n_checks++; if (wa_log.size() - base !== 0) begin n_errors++; $display("FAIL partial_no_write got %0d want 0", wa_log.size() - base); end
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL partial_busy got %b want 0", busy); end
        bus_start();
        byte_out(8'h42, a); byte_out(8'h21, a); byte_out(8'h3C, a);
        bus_stop();
        n_checks++; if (a !== 1'b1) begin n_errors++; $display("FAIL partial_next_ack got %b want 1", a); end
        n_checks++; if (wa_log.size() - base !== 1) begin n_errors++; $display("FAIL partial_next_count got %0d want 1", wa_log.size() - base); end
        else begin
            n_checks++;
            if (wa_log[base] !== 16'h0021 || wd_log[base] !== 8'h3C) begin
                n_errors++; $display("FAIL partial_next_write got %h=%h want 0021=3c", wa_log[base], wd_log[base]);
            end
        end
    endtask

    task automatic test_reset_mid_ack();
        logic       a;
        logic [7:0] r;
        logic [7:0] v = 8'h66;
        int base = wa_log.size();
        bus_start();
        byte_out(8'h42, a); byte_out(8'h30, a);
        for (int i = 7; i >= 0; i--) bit_out(v[i]);
        #20 sda_m = 1'b1;
        #60 scl_m = 1'b1;
        #20;
        n_checks++; if (sda_oe !== 1'b1) begin n_errors++; $display("FAIL rstack_pre_oe got %b want 1", sda_oe); end
        rst = 1'b1;
        #1;
        n_checks++; if (sda_oe !== 1'b0) begin n_errors++; $display("FAIL rstack_async_oe got %b want 0", sda_oe); end
        n_checks++; if ({busy, reg_wr_en, reg_wr_addr, reg_wr_data} !== 26'h0) begin
            n_errors++; $display("FAIL rstack_outputs got %b/%b/%h/%h want 0/0/0000/00", busy, reg_wr_en, reg_wr_addr, reg_wr_data); end
        n_checks++; if (dbg_data !== 8'h00) begin n_errors++; $display("FAIL rstack_dbg got %h want 00", dbg_data); end
        #19 rst = 1'b0;
        #20 scl_m = 1'b0;
        bus_stop();
        n_checks++;
        if (wa_log.size() - base !== 1 || wa_log[base] !== 16'h0030 || wd_log[base] !== 8'h66) begin
            n_errors++; $display("FAIL rstack_write_before_reset count %0d want 1 (0030=66)", wa_log.size() - base);
        end
        bus_start();
        byte_out(8'h43, a);
        byte_in(r);
        bit_out(1'b1);
        bus_stop();
        n_checks++; if (a !== 1'b1) begin n_errors++; $display("FAIL rstack_read_ack got %b want 1", a); end
        n_checks++; if (r !== 8'hA2) begin n_errors++; $display("FAIL rstack_ptr_zero got %h want a2", r); end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_wrong_dev();
        test_burst_wrap();
        test_two_phase_read();
        test_partial_stop();
        test_reset_mid_ack();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
